// File: rtl/interboard_pkg.sv
// Interboard link shared definitions.
// Message layout, word split and send FSM states.
package interboard_pkg;

    localparam int WORDS_PER_MSG = 4;
    localparam int MSG_W         = 24;
    localparam int DATA_W        = 6;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_REQ_HI = 2'd2,
        S_REQ_LO = 2'd3
    } state_e;

    // Two zero pad bits keep word0 from ever reading as all-ones.
    function automatic logic [MSG_W-1:0] pack_msg(
        input logic [3:0] msg_type,
        input logic       move_dir,
        input logic [4:0] block_x,
        input logic [2:0] block_y,
        input logic [5:0] card,
        input logic [2:0] sel_len
    );
        return {2'b00, msg_type, move_dir, block_x,
                block_y, card, sel_len};
    endfunction

    function automatic logic [DATA_W-1:0] msg_word(
        input logic [MSG_W-1:0] msg,
        input logic [1:0]       idx
    );
        logic [MSG_W-1:0] sh;
        sh = msg << (DATA_W * int'(idx));
        return sh[MSG_W-1 -: DATA_W];
    endfunction

endpackage

// File: rtl/interboard_msg_fifo.sv
// Message FIFO for the interboard send path.
// Async reset plus synchronous clear; pointers wrap modulo DEPTH.
module interboard_msg_fifo
    import interboard_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = MSG_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign rdata   = mem_q[rptr_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_push) wptr_d = wptr_q + 1'b1;
        if (do_pop)  rptr_d = rptr_q + 1'b1;
        if (do_push && !do_pop) count_d = count_q + 1'b1;
        if (do_pop && !do_push) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else if (clr) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clr) mem_q[wptr_q] <= wdata;
    end

endmodule

// File: rtl/interboard_msg_sender.sv
// Interboard send path: queues control messages and ships each
// as four 6-bit words over a 4-phase Request/Ack handshake.
module interboard_msg_sender
    import interboard_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 1_000_000,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              interboard_rst,
    input  logic              Ack_in,
    input  logic              ctrl_en,
    input  logic              ctrl_move_dir,
    input  logic [4:0]        ctrl_block_x,
    input  logic [2:0]        ctrl_block_y,
    input  logic [3:0]        ctrl_msg_type,
    input  logic [5:0]        ctrl_card,
    input  logic [2:0]        ctrl_sel_len,
    output logic              Request_out,
    output logic [DATA_W-1:0] inter_data_out,
    output logic              busy,
    output logic              fifo_full,
    output logic              overflow,
    output logic              timeout_err
);

    localparam int TW = $clog2(TIMEOUT_CYC);

    state_e                 state_q, state_d;
    logic [MSG_W-1:0]       msg_q, msg_d;
    logic [1:0]             idx_q, idx_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   req_q, req_d;
    logic [DATA_W-1:0]      data_q, data_d;
    logic                   ovf_q, ovf_d;
    logic                   to_q, to_d;

    logic                   ack_s;
    logic                   timeout;
    logic                   expired;
    logic                   fifo_push, fifo_pop;
    logic                   fifo_empty, fifo_full_w;
    logic [MSG_W-1:0]       fifo_wdata, fifo_rdata;

    assign ack_s      = sync_q[SYNC_STAGES-1];
    assign expired    = (timer_q == TW'(TIMEOUT_CYC - 1));
    assign fifo_wdata = pack_msg(ctrl_msg_type, ctrl_move_dir,
                                 ctrl_block_x, ctrl_block_y,
                                 ctrl_card, ctrl_sel_len);
    assign fifo_push  = ctrl_en && (!fifo_full_w || fifo_pop);

    interboard_msg_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (MSG_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (interboard_rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (fifo_wdata),
        .rdata (fifo_rdata),
        .full  (fifo_full_w),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            msg_q   <= '0;
            idx_q   <= '0;
            timer_q <= '0;
            sync_q  <= '0;
            req_q   <= 1'b0;
            data_q  <= '0;
            ovf_q   <= 1'b0;
            to_q    <= 1'b0;
        end else if (interboard_rst) begin
            state_q <= S_IDLE;
            msg_q   <= '0;
            idx_q   <= '0;
            timer_q <= '0;
            sync_q  <= '0;
            req_q   <= 1'b0;
            data_q  <= '0;
            ovf_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            msg_q   <= msg_d;
            idx_q   <= idx_d;
            timer_q <= timer_d;
            sync_q  <= {sync_q[SYNC_STAGES-2:0], Ack_in};
            req_q   <= req_d;
            data_q  <= data_d;
            ovf_q   <= ovf_d;
            to_q    <= to_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        msg_d    = msg_q;
        idx_d    = idx_q;
        fifo_pop = 1'b0;
        timeout  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    msg_d    = fifo_rdata;
                    idx_d    = '0;
                    state_d  = S_SETUP;
                end
            end
            S_SETUP: state_d = S_REQ_HI;
            S_REQ_HI: begin
                if (expired) begin
                    timeout = 1'b1;
                    state_d = S_IDLE;
                end else if (ack_s) begin
                    state_d = S_REQ_LO;
                end
            end
            S_REQ_LO: begin
                if (expired) begin
                    timeout = 1'b1;
                    state_d = S_IDLE;
                end else if (!ack_s) begin
                    if (idx_q == 2'(WORDS_PER_MSG - 1)) begin
                        state_d = S_IDLE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_SETUP;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Timer restarts on every state entry, counts only while waiting.
        timer_d = '0;
        if ((state_q == S_REQ_HI || state_q == S_REQ_LO)
            && state_d == state_q)
            timer_d = timer_q + 1'b1;
    end

    always_comb begin
        req_d  = (state_d == S_REQ_HI);
        data_d = data_q;
        if (state_d == S_SETUP) data_d = msg_word(msg_d, idx_d);
        ovf_d  = ctrl_en && fifo_full_w && !fifo_pop;
        to_d   = timeout;
    end

    assign Request_out    = req_q;
    assign inter_data_out = data_q;
    assign overflow       = ovf_q;
    assign timeout_err    = to_q;
    assign fifo_full      = fifo_full_w;
    assign busy           = (state_q != S_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_interboard_msg_sender.sv
// Bench for interboard_msg_sender: vector table, handshake corner
// sequences and random bursts against an arithmetic word model.
module tb_interboard_msg_sender;

    localparam int DEPTH = 4;
    localparam int TOUT  = 20;
    localparam int SYNC  = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       interboard_rst = 1'b0;
    logic       Ack_in = 1'b0;
    logic       ctrl_en = 1'b0;
    logic       ctrl_move_dir = 1'b0;
    logic [4:0] ctrl_block_x = '0;
    logic [2:0] ctrl_block_y = '0;
    logic [3:0] ctrl_msg_type = '0;
    logic [5:0] ctrl_card = '0;
    logic [2:0] ctrl_sel_len = '0;
    logic       Request_out;
    logic [5:0] inter_data_out;
    logic       busy, fifo_full, overflow, timeout_err;

    always #5 clk = ~clk;

    interboard_msg_sender #(
        .FIFO_DEPTH  (DEPTH),
        .TIMEOUT_CYC (TOUT),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .interboard_rst (interboard_rst),
        .Ack_in         (Ack_in),
        .ctrl_en        (ctrl_en),
        .ctrl_move_dir  (ctrl_move_dir),
        .ctrl_block_x   (ctrl_block_x),
        .ctrl_block_y   (ctrl_block_y),
        .ctrl_msg_type  (ctrl_msg_type),
        .ctrl_card      (ctrl_card),
        .ctrl_sel_len   (ctrl_sel_len),
        .Request_out    (Request_out),
        .inter_data_out (inter_data_out),
        .busy           (busy),
        .fifo_full      (fifo_full),
        .overflow       (overflow),
        .timeout_err    (timeout_err)
    );

    typedef struct {
        logic [3:0] typ;
        logic       dir;
        logic [4:0] x;
        logic [2:0] y;
        logic [5:0] card;
        logic [2:0] len;
    } msg_t;

    typedef struct {
        msg_t       m;
        logic [5:0] w [4];
    } vec_t;

    int         n_chk = 0;
    int         n_fail = 0;
    logic [5:0] rx_q [$];
    logic [5:0] exp_q [$];
    int         prot_err = 0;
    int         ovf_cnt = 0;
    int         full_cnt = 0;
    int         to_cnt = 0;
    bit         chk_en = 1'b1;
    bit         rx_hold = 1'b0;
    int         ack_dly = 1;
    logic       req_prev = 1'b0;
    logic [5:0] data_prev = '0;
    int         ack_cnt = 0;

    // Receiver: follows Request with Ack after ack_dly cycles.
    always @(negedge clk) begin
        if (rx_hold) begin
            Ack_in = 1'b0;
            ack_cnt = 0;
        end else if (Request_out != Ack_in) begin
            if (ack_cnt >= ack_dly) begin
                Ack_in = Request_out;
                ack_cnt = 0;
            end else begin
                ack_cnt++;
            end
        end else begin
            ack_cnt = 0;
        end
    end

    always @(negedge clk) begin
        if (Request_out && !req_prev) rx_q.push_back(inter_data_out);
        if (chk_en && inter_data_out != data_prev
            && (Request_out || req_prev)) begin
            prot_err++;
        end
        if (overflow)    ovf_cnt++;
        if (fifo_full)   full_cnt++;
        if (timeout_err) to_cnt++;
        req_prev  = Request_out;
        data_prev = inter_data_out;
    end

    task automatic check(input string nm,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [5:0] model_word(input msg_t m, input int k);
        int v;
        v = int'(m.typ);
        v = v * 2  + int'(m.dir);
        v = v * 32 + int'(m.x);
        v = v * 8  + int'(m.y);
        v = v * 64 + int'(m.card);
        v = v * 8  + int'(m.len);
        return 6'((v >> (18 - 6 * k)) & 63);
    endfunction

    function automatic msg_t mk(input logic [3:0] t, input logic d,
                                input logic [4:0] x, input logic [2:0] y,
                                input logic [5:0] c, input logic [2:0] l);
        msg_t m;
        m.typ = t; m.dir = d; m.x = x; m.y = y; m.card = c; m.len = l;
        return m;
    endfunction

    function automatic msg_t rand_msg();
        return mk(4'($urandom), 1'($urandom), 5'($urandom),
                  3'($urandom), 6'($urandom), 3'($urandom));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input msg_t m);
        ctrl_msg_type = m.typ;
        ctrl_move_dir = m.dir;
        ctrl_block_x  = m.x;
        ctrl_block_y  = m.y;
        ctrl_card     = m.card;
        ctrl_sel_len  = m.len;
    endtask

    task automatic send(input msg_t m);
        drive(m);
        ctrl_en = 1'b1;
        tick();
        ctrl_en = 1'b0;
    endtask

    task automatic send_exp(input msg_t m);
        send(m);
        for (int k = 0; k < 4; k++) exp_q.push_back(model_word(m, k));
    endtask

    task automatic wait_idle(input string nm, input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        check({nm, " idle"}, 32'(busy), 32'd0);
        check({nm, " ack low"}, 32'(Ack_in), 32'd0);
    endtask

    task automatic compare_rx(input string nm);
        check({nm, " count"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("%s w%0d", nm, i),
                  (i < rx_q.size()) ? 32'(rx_q[i]) : 32'hDEAD,
                  32'(exp_q[i]));
        end
        rx_q.delete();
        exp_q.delete();
    endtask

    vec_t vecs [4];

    initial begin
        msg_t m1, m2;
        int   n, nb;

        vecs[0].m = mk(4'h9, 1'b1, 5'd17, 3'd4, 6'h2A, 3'd3);
        vecs[0].w = '{6'h09, 6'h31, 6'h25, 6'h13};
        vecs[1].m = mk(4'hF, 1'b1, 5'h1F, 3'd7, 6'h3F, 3'd7);
        vecs[1].w = '{6'h0F, 6'h3F, 6'h3F, 6'h3F};
        vecs[2].m = mk(4'h0, 1'b0, 5'h00, 3'd0, 6'h00, 3'd0);
        vecs[2].w = '{6'h00, 6'h00, 6'h00, 6'h00};
        vecs[3].m = mk(4'hA, 1'b0, 5'h05, 3'd2, 6'h15, 3'd5);
        vecs[3].w = '{6'h0A, 6'h05, 6'h12, 6'h2D};

        repeat (3) @(posedge clk);
        #1;
        check("rst req", 32'(Request_out), 32'd0);
        check("rst data", 32'(inter_data_out), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst full", 32'(fifo_full), 32'd0);
        check("rst ovf", 32'(overflow), 32'd0);
        check("rst tout", 32'(timeout_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        ack_dly = 5;
        foreach (vecs[i]) begin
            rx_q.delete();
            send(vecs[i].m);
            wait_idle($sformatf("vec%0d", i), 400);
            check($sformatf("vec%0d count", i), rx_q.size(), 32'd4);
            for (int k = 0; k < 4; k++) begin
                check($sformatf("vec%0d w%0d", i, k),
                      (k < rx_q.size()) ? 32'(rx_q[k]) : 32'hDEAD,
                      32'(vecs[i].w[k]));
            end
            rx_q.delete();
        end

        ack_dly = 1;
        ovf_cnt = 0;
        full_cnt = 0;
        for (int i = 0; i < 3; i++) send_exp(rand_msg());
        wait_idle("b2b", 600);
        compare_rx("b2b");
        check("b2b ovf", ovf_cnt, 32'd0);
        check("b2b full", full_cnt, 32'd0);

        rx_hold = 1'b1;
        ovf_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (i < 5) send_exp(rand_msg());
            else send(rand_msg());
        end
        check("fill full", 32'(fifo_full), 32'd1);
        check("fill ovf pulse", 32'(overflow), 32'd1);
        rx_hold = 1'b0;
        wait_idle("fill", 1500);
        compare_rx("fill");
        check("fill ovf count", ovf_cnt, 32'd1);

        rx_hold = 1'b1;
        to_cnt = 0;
        m1 = rand_msg();
        m2 = rand_msg();
        send(m1);
        send(m2);
        exp_q.push_back(model_word(m1, 0));
        for (int k = 0; k < 4; k++) exp_q.push_back(model_word(m2, k));
        n = 0;
        while (!Request_out && n < 20) begin tick(); n++; end
        check("tout req rise", 32'(Request_out), 32'd1);
        n = 0;
        while (!timeout_err && n < 40) begin tick(); n++; end
        check("tout latency", n, TOUT);
        check("tout req low", 32'(Request_out), 32'd0);
        n = 0;
        while (!Request_out && n < 20) begin tick(); n++; end
        check("tout restart", n, 32'd2);
        check("tout next data", 32'(inter_data_out),
              32'(model_word(m2, 0)));
        rx_hold = 1'b0;
        wait_idle("tout", 600);
        compare_rx("tout");
        check("tout count", to_cnt, 32'd1);

        ack_dly = 2;
        for (int i = 0; i < 3; i++) send(rand_msg());
        n = 0;
        while (rx_q.size() < 3 && n < 400) begin tick(); n++; end
        check("ibrst reach w2", rx_q.size(), 32'd3);
        chk_en = 1'b0;
        drive(rand_msg());
        interboard_rst = 1'b1;
        ctrl_en = 1'b1;
        tick();
        interboard_rst = 1'b0;
        ctrl_en = 1'b0;
        check("ibrst req", 32'(Request_out), 32'd0);
        check("ibrst data", 32'(inter_data_out), 32'd0);
        check("ibrst busy", 32'(busy), 32'd0);
        check("ibrst full", 32'(fifo_full), 32'd0);
        repeat (100) tick();
        check("ibrst silent", rx_q.size(), 32'd3);
        check("ibrst still idle", 32'(busy), 32'd0);
        chk_en = 1'b1;
        rx_q.delete();

        ack_dly = 3;
        send(vecs[0].m);
        n = 0;
        while (!(rx_q.size() == 1 && !Request_out) && n < 300) begin
            tick();
            n++;
        end
        check("arst in req_lo", 32'(Request_out), 32'd0);
        check("arst data before", 32'(inter_data_out), 32'h09);
        chk_en = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("arst req", 32'(Request_out), 32'd0);
        check("arst data", 32'(inter_data_out), 32'd0);
        check("arst busy", 32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
        repeat (50) tick();
        check("arst silent", rx_q.size(), 32'd1);
        check("arst idle", 32'(busy), 32'd0);
        chk_en = 1'b1;
        rx_q.delete();

        ovf_cnt = 0;
        to_cnt = 0;
        for (int b = 0; b < 8; b++) begin
            ack_dly = $urandom_range(0, 6);
            nb = $urandom_range(1, 4);
            for (int i = 0; i < nb; i++) begin
                send_exp(rand_msg());
                if ($urandom_range(0, 1) == 1) tick();
            end
            wait_idle($sformatf("rnd%0d", b), 1000);
        end
        compare_rx("rnd");
        check("rnd ovf", ovf_cnt, 32'd0);
        check("rnd tout", to_cnt, 32'd0);
        check("protocol data stable", prot_err, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
